// File: rtl/mux_escaneo_param.sv
// Registered N-channel multiplexer with manual select and masked round-robin scan.
// Outputs are all registered; o_Cambio pulses in the cycle a new o_Canal first appears.
module mux_escaneo_param #(
    parameter  int WIDTH    = 4,
    parameter  int CHANNELS = 4,
    parameter  int DWELL    = 1000,
    localparam int SEL_W    = $clog2(CHANNELS),
    localparam int CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst,
    input  logic [CHANNELS*WIDTH-1:0] i_Datos,
    input  logic [SEL_W-1:0]          i_Sel,
    input  logic                      i_Modo,
    input  logic                      i_Enable,
    input  logic [CHANNELS-1:0]       i_Mask,
    output logic [WIDTH-1:0]          o_Salida,
    output logic [SEL_W-1:0]          o_Canal,
    output logic [CHANNELS-1:0]       o_Onehot,
    output logic                      o_Cambio
);

    localparam logic [CNT_W-1:0]    CNT_FIN = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]    ULTIMO  = SEL_W'(CHANNELS - 1);
    localparam logic [CHANNELS-1:0] UNO     = {{(CHANNELS-1){1'b0}}, 1'b1};

    logic [SEL_W-1:0]    r_Canal;
    logic [CNT_W-1:0]    r_Cnt;
    logic [WIDTH-1:0]    r_Salida;
    logic [CHANNELS-1:0] r_Onehot;
    logic                r_Cambio;

    logic [SEL_W-1:0]    w_SelSat;
    logic [SEL_W-1:0]    w_Busca;
    logic [SEL_W-1:0]    w_Sig;
    logic [CNT_W-1:0]    w_CntSig;
    logic [CHANNELS-1:0] w_OnehotSig;
    logic [WIDTH-1:0]    w_DatoSig;

    assign w_SelSat = (int'(i_Sel) >= CHANNELS) ? ULTIMO : i_Sel;

    // Descending sweep so the last hit is the nearest unmasked channel above r_Canal;
    // k = CHANNELS wraps back onto r_Canal itself when it is the only one enabled.
    always_comb begin : busqueda
        w_Busca = r_Canal;
        for (int k = CHANNELS; k >= 1; k--) begin
            if (i_Mask[(int'(r_Canal) + k) % CHANNELS]) begin
                w_Busca = SEL_W'((int'(r_Canal) + k) % CHANNELS);
            end
        end
    end

    always_comb begin : siguiente
        w_Sig       = r_Canal;
        w_CntSig    = r_Cnt;
        w_OnehotSig = '0;
        if (!i_Modo) begin
            w_Sig    = w_SelSat;
            w_CntSig = '0;
        end else if (i_Mask != '0) begin
            if (!i_Mask[r_Canal] || (r_Cnt == CNT_FIN)) begin
                w_Sig    = w_Busca;
                w_CntSig = '0;
            end else begin
                w_CntSig = r_Cnt + 1'b1;
            end
        end
        if (!i_Modo || i_Mask[w_Sig]) begin
            w_OnehotSig = UNO << w_Sig;
        end
    end

    assign w_DatoSig = i_Datos[w_Sig*WIDTH +: WIDTH];

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Canal  <= '0;
            r_Cnt    <= '0;
            r_Salida <= '0;
            r_Onehot <= '0;
            r_Cambio <= 1'b0;
        end else if (i_Enable) begin
            r_Canal  <= w_Sig;
            r_Cnt    <= w_CntSig;
            r_Salida <= w_DatoSig;
            r_Onehot <= w_OnehotSig;
            r_Cambio <= (w_Sig != r_Canal);
        end else begin
            r_Cambio <= 1'b0;
        end
    end

    assign o_Salida = r_Salida;
    assign o_Canal  = r_Canal;
    assign o_Onehot = r_Onehot;
    assign o_Cambio = r_Cambio;

endmodule

// File: tb/tb_mux_escaneo_param.sv
// Bench for mux_escaneo_param: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the multiplexer.
module tb_mux_escaneo_param;

    localparam int W = 4;
    localparam int C = 4;
    localparam int D = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [C*W-1:0] datos;
    logic [1:0]     sel;
    logic           modo;
    logic           en;
    logic [C-1:0]   mask;
    wire  [W-1:0]   o_sal;
    wire  [1:0]     o_can;
    wire  [C-1:0]   o_oh;
    wire            o_cam;

    logic [3*W-1:0] datos3;
    logic [1:0]     sel3;
    wire  [W-1:0]   sal3;
    wire  [1:0]     can3;
    wire  [2:0]     oh3;
    wire            cam3;

    int vectors = 0;
    int errors  = 0;

    int           m_canal;
    int           m_cnt;
    logic [W-1:0] m_sal;
    logic [C-1:0] m_oh;
    logic         m_cam;

    wire [W+C+2:0] dut_vec = {o_sal, o_can, o_oh, o_cam};

    always #5 clk = ~clk;

    mux_escaneo_param #(.WIDTH(W), .CHANNELS(C), .DWELL(D)) u_dut (
        .i_Clk(clk), .i_Rst(rst), .i_Datos(datos), .i_Sel(sel), .i_Modo(modo),
        .i_Enable(en), .i_Mask(mask), .o_Salida(o_sal), .o_Canal(o_can),
        .o_Onehot(o_oh), .o_Cambio(o_cam)
    );

    mux_escaneo_param #(.WIDTH(W), .CHANNELS(3), .DWELL(2)) u_dut3 (
        .i_Clk(clk), .i_Rst(rst), .i_Datos(datos3), .i_Sel(sel3), .i_Modo(1'b0),
        .i_Enable(1'b1), .i_Mask(3'b111), .o_Salida(sal3), .o_Canal(can3),
        .o_Onehot(oh3), .o_Cambio(cam3)
    );

    function automatic logic [W+C+2:0] exp_vec();
        return {m_sal, 2'(m_canal), m_oh, m_cam};
    endfunction

    function automatic int next_unmasked(int cur, logic [C-1:0] mk);
        int lst[$];
        for (int k = 0; k < C; k++) if (mk[k]) lst.push_back(k);
        foreach (lst[i]) if (lst[i] > cur) return lst[i];
        return lst[0];
    endfunction

    function automatic void model_clear();
        m_canal = 0; m_cnt = 0; m_sal = '0; m_oh = '0; m_cam = 1'b0;
    endfunction

    // m_cnt counts cycles already spent on the current channel.
    function automatic void model_step();
        int prev;
        int n;
        prev = m_canal;
        n    = prev;
        if (!en) begin
            m_cam = 1'b0;
            return;
        end
        m_oh = '0;
        if (!modo) begin
            n = int'(sel);
            m_cnt = 0;
            m_oh[n] = 1'b1;
        end else if (mask != '0) begin
            m_cnt++;
            if (!mask[prev] || m_cnt == D) begin
                n = next_unmasked(prev, mask);
                m_cnt = 0;
            end
            m_oh[n] = 1'b1;
        end
        m_sal   = datos[n*W +: W];
        m_cam   = (n != prev);
        m_canal = n;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_clear();
        else model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; modo = 1'b0; sel = 2'd0; mask = 4'hF;
        datos = 16'hDCBA; datos3 = '0; sel3 = 2'd0;
        model_clear();
        #2;
        vectors++;
        if (dut_vec !== '0) begin
            errors++; $display("FAIL reset_async: got %h expected 0", dut_vec);
        end
        tick();
        vectors++;
        if (dut_vec !== '0) begin
            errors++; $display("FAIL reset_held: got %h expected 0", dut_vec);
        end
        rst = 1'b0;
    endtask

    task automatic test_manual();
        logic [C-1:0] eoh;
        for (int i = 0; i < C; i++) begin
            sel = 2'(i);
            tick();
            eoh = '0; eoh[i] = 1'b1;
            vectors++;
            if (dut_vec !== {4'hA + 4'(i), 2'(i), eoh, (i != 0)}) begin
                errors++; $display("FAIL manual_sel%0d: got %h expected %h", i, dut_vec, {4'hA + 4'(i), 2'(i), eoh, (i != 0)});
            end
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL manual_model%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_out_of_range();
        sel3 = 2'd3; datos3 = {4'h5, 4'h1, 4'h2};
        tick();
        vectors++;
        if ({sal3, can3, oh3} !== {4'h5, 2'd2, 3'b100}) begin
            errors++; $display("FAIL oor_sel: got %h expected %h", {sal3, can3, oh3}, {4'h5, 2'd2, 3'b100});
        end
        datos3[11:8] = 4'h9;
        tick();
        vectors++;
        if ({sal3, can3, oh3, cam3} !== {4'h9, 2'd2, 3'b100, 1'b0}) begin
            errors++; $display("FAIL oor_track: got %h expected %h", {sal3, can3, oh3, cam3}, {4'h9, 2'd2, 3'b100, 1'b0});
        end
    endtask

    task automatic test_scan_mask();
        int seq[12] = '{0, 0, 1, 1, 1, 3, 3, 3, 0, 0, 0, 1};
        rst = 1'b1;
        #1;
        model_clear();
        tick();
        rst = 1'b0; modo = 1'b1; mask = 4'b1011;
        for (int i = 0; i < 12; i++) begin
            tick();
            vectors++;
            if (int'(o_can) !== seq[i]) begin
                errors++; $display("FAIL scan_seq%0d: got channel %0d expected %0d", i, o_can, seq[i]);
            end
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL scan_model%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_mask_mid();
        tick();
        mask = 4'b1001;
        tick();
        vectors++;
        if ({o_can, o_oh, o_cam} !== {2'd3, 4'b1000, 1'b1}) begin
            errors++; $display("FAIL mask_mid_jump: got %h expected %h", {o_can, o_oh, o_cam}, {2'd3, 4'b1000, 1'b1});
        end
        tick();
        tick();
        vectors++;
        if (o_can !== 2'd3) begin
            errors++; $display("FAIL mask_mid_restart: got channel %0d expected 3", o_can);
        end
        tick();
        vectors++;
        if (o_can !== 2'd0) begin
            errors++; $display("FAIL mask_mid_next: got channel %0d expected 0", o_can);
        end
        mask = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            datos[3:0] = 4'(i + 3);
            tick();
            vectors++;
            if ({o_sal, o_can, o_oh, o_cam} !== {4'(i + 3), 2'd0, 4'b0000, 1'b0}) begin
                errors++; $display("FAIL mask_zero%0d: got %h expected %h", i, {o_sal, o_can, o_oh, o_cam}, {4'(i + 3), 2'd0, 4'b0000, 1'b0});
            end
        end
    endtask

    task automatic test_freeze();
        logic [W+C+2:0] held;
        mask = 4'b1111;
        tick();
        held = dut_vec;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            datos = 16'(datos + 16'h1111);
            tick();
            vectors++;
            if (dut_vec !== {held[W+C+2:1], 1'b0}) begin
                errors++; $display("FAIL freeze_hold%0d: got %h expected %h", i, dut_vec, {held[W+C+2:1], 1'b0});
            end
        end
        en = 1'b1;
        tick();
        vectors++;
        if (o_can !== 2'd0) begin
            errors++; $display("FAIL freeze_resume: got channel %0d expected 0", o_can);
        end
        tick();
        vectors++;
        if ({o_can, o_cam} !== {2'd1, 1'b1}) begin
            errors++; $display("FAIL freeze_advance: got %h expected %h", {o_can, o_cam}, {2'd1, 1'b1});
        end
        vectors++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL freeze_model: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_reset_mode();
        rst = 1'b1;
        #1;
        vectors++;
        if (dut_vec !== '0) begin
            errors++; $display("FAIL reset_midscan: got %h expected 0", dut_vec);
        end
        model_clear();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        vectors++;
        if (o_can !== 2'd2) begin
            errors++; $display("FAIL rescan_ch2: got channel %0d expected 2", o_can);
        end
        modo = 1'b0; sel = 2'd1;
        tick();
        vectors++;
        if ({o_can, o_oh, o_cam} !== {2'd1, 4'b0010, 1'b1}) begin
            errors++; $display("FAIL to_manual: got %h expected %h", {o_can, o_oh, o_cam}, {2'd1, 4'b0010, 1'b1});
        end
        modo = 1'b1; sel = 2'd3;
        tick();
        vectors++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL to_scan: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            datos = 16'($urandom);
            if ($urandom_range(0, 7) == 0) modo = 1'($urandom);
            if ($urandom_range(0, 3) == 0) sel = 2'($urandom);
            if ($urandom_range(0, 9) == 0) mask = 4'($urandom);
            en = ($urandom_range(0, 9) != 0);
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_manual();
        test_out_of_range();
        test_scan_mask();
        test_mask_mid();
        test_freeze();
        test_reset_mode();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
